// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: one-hot state codes,
// the busy-handshake timeout and the line-feed byte that ends a locked line.
package uart_pkg;

  localparam logic [3:0] ST_IDLE      = 4'b0001;
  localparam logic [3:0] ST_ISSUE     = 4'b0010;
  localparam logic [3:0] ST_WAIT_BUSY = 4'b0100;
  localparam logic [3:0] ST_WAIT_DONE = 4'b1000;

  localparam int         BUSY_TIMEOUT = 4;
  localparam logic [7:0] LF           = 8'h0A;

endpackage

// File: rtl/uart_arb_rr.sv
// Combinational round-robin picker: returns the first set bit of mask found
// by scanning upward from start and wrapping modulo N.
module uart_arb_rr #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [W:0]   sum;
  logic [W-1:0] idx;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    // Scan from the farthest offset down so the nearest candidate is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (W+1)'(i);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      idx = sum[W-1:0];
      if (mask[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART transmitter.
// Optional line lock (hold a requester until it sends LF) is enabled by UART_ARB_LINE_LOCK_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                       clk_48,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_w,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       err
);

  localparam int GW = $clog2(N_REQ);

  logic [3:0]    state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_w_q, tx_w_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] rr_start_q, rr_start_d;
  logic          err_q, err_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [GW-1:0] lock_id_q, lock_id_d;

  logic [N_REQ-1:0] eligible;
  logic [GW-1:0]    winner;
  logic             found;
  logic [7:0]       win_byte;

`ifdef UART_ARB_LINE_LOCK_EN
  assign eligible = lock_q ? (req_valid & (N_REQ'(1) << lock_id_q)) : req_valid;
`else
  assign eligible = req_valid;
`endif

  uart_arb_rr #(.N(N_REQ), .W(GW)) u_rr (
    .mask   (eligible),
    .start  (rr_start_q),
    .winner (winner),
    .found  (found)
  );

  assign win_byte = req_data[{winner, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_w_d     = 1'b0;
    grant_id_d = grant_id_q;
    rr_start_d = rr_start_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    req_ready  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!tx_busy && found) begin
          req_ready[winner] = 1'b1;
          tx_data_d         = win_byte;
          grant_id_d        = winner;
          rr_start_d        = (winner == GW'(N_REQ - 1)) ? '0 : winner + GW'(1);
          // tx_w is registered, so raising it here makes it high for exactly the ISSUE cycle.
          tx_w_d            = 1'b1;
          state_d           = ST_ISSUE;
`ifdef UART_ARB_LINE_LOCK_EN
          lock_d            = (win_byte != LF);
          lock_id_d         = winner;
`endif
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == 3'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_w_q     <= 1'b0;
      grant_id_q <= '0;
      rr_start_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_w_q     <= tx_w_d;
      grant_id_q <= grant_id_d;
      rr_start_q <= rr_start_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_w     = tx_w_q;
  assign grant_id = grant_id_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed requester streams push expected
// (byte, grant) pairs; a monitor pops and compares on every tx_w pulse.
module tb_uart_tx_arb;

  localparam int N = 3;

  logic           clk_48 = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_w;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           err;

  always #10 clk_48 = ~clk_48;

  uart_tx_arb #(.N_REQ(N)) dut (
    .clk_48    (clk_48),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_w      (tx_w),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .err       (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_48) cyc <= cyc + 1;

  // UART model: busy for busy_len cycles after each accepted write; not reset by rst_n.
  logic uart_en  = 1'b1;
  logic ext_busy = 1'b0;
  int   busy_len = 5;
  int   busy_cnt = 0;

  always @(posedge clk_48) begin
    if (tx_w && uart_en) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0) || ext_busy;

  typedef struct {
    logic [7:0] data;
    int         gid;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Requester models: small per-requester byte FIFOs presented on req_valid/req_data.
  logic [7:0] rbuf[N][8];
  int         rhead[N];
  int         rtail[N];
  logic [N-1:0] acc = '0;

  task automatic push_req(input int i, input logic [7:0] b);
    rbuf[i][rtail[i]] = b;
    rtail[i]++;
  endtask

  task automatic push_exp(input logic [7:0] b, input int gid);
    exp_t x;
    x.data = b;
    x.gid  = gid;
    exp_q.push_back(x);
  endtask

  always @(posedge clk_48) begin
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) rhead[i]++;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rhead[i] < rtail[i]);
      req_data[8*i +: 8] = req_valid[i] ? rbuf[i][rhead[i]] : 8'h00;
    end
  end

  // Monitor / scoreboard.
  bit chk_gap = 1'b0;
  int prev_tx = -1;
  int last_tx = -1;

  always @(negedge clk_48) begin
    acc = req_ready & req_valid;
    if (req_ready != '0) begin
      check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
    end
    if (tx_w) begin
      if (exp_q.size() == 0) begin
        check("tx_w_unexpected", 32'(tx_w), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("grant_id", 32'(grant_id), 32'(e.gid));
      end
      check("busy_at_tx_w", 32'(tx_busy), 32'd0);
      if (chk_gap && prev_tx >= 0) check("tx_gap", 32'(cyc - prev_tx), 32'(busy_len + 3));
      prev_tx = cyc;
      last_tx = cyc;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_48);
  endtask

  task automatic wait_exp_empty(input int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge clk_48);
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (tx_busy && k < 200) begin
      @(negedge clk_48);
      k++;
    end
    repeat (8) @(negedge clk_48);
  endtask

  task automatic do_reset();
    @(negedge clk_48);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    repeat (2) @(negedge clk_48);
    rst_n = 1'b1;
    @(negedge clk_48);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t0;
    int early;
    for (int i = 0; i < N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk_48);
    check("rst_tx_w", 32'(tx_w), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_48);

    // Single byte from requester 0: ready one cycle, tx_w the next
    busy_len = 3;
    push_req(0, 8'h41);
    push_exp(8'h41, 0);
    k = 0;
    while (!req_ready[0] && k < 20) begin
      @(negedge clk_48);
      k++;
    end
    check("single_ready", 32'(req_ready), 32'b001);
    check("single_no_tx_w_yet", 32'(tx_w), 32'd0);
    @(negedge clk_48);
    check("single_tx_w", 32'(tx_w), 32'd1);
    check("single_ready_dropped", 32'(req_ready), 32'd0);
    check("single_tx_data", 32'(tx_data), 32'h41);
    @(negedge clk_48);
    check("single_tx_w_pulse", 32'(tx_w), 32'd0);
    wait_exp_empty(20);

    // Three requesters always valid: strict 0,1,2 rotation at busy+3 spacing
    wait_idle();
    do_reset();
    busy_len = 5;
    prev_tx  = -1;
    chk_gap  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_req(0, 8'hA0);
      push_req(1, 8'hB1);
      push_req(2, 8'hC2);
    end
    for (int r = 0; r < 2; r++) begin
      push_exp(8'hA0, 0);
      push_exp(8'hB1, 1);
      push_exp(8'hC2, 2);
    end
    wait_exp_empty(150);
    chk_gap = 1'b0;

    // UART never goes busy: err five cycles after tx_w, then next request accepted
    wait_idle();
    do_reset();
    uart_en = 1'b0;
    push_req(1, 8'h55);
    push_exp(8'h55, 1);
    wait_exp_empty(20);
    t0 = last_tx;
    wait_cyc(t0 + 2);
    uart_en = 1'b1;
    push_req(2, 8'h66);
    push_exp(8'h66, 2);
    wait_cyc(t0 + 3);
    check("timeout_no_ready_wait_busy", 32'(req_ready), 32'd0);
    wait_cyc(t0 + 4);
    check("timeout_err_not_yet", 32'(err), 32'd0);
    check("timeout_no_ready_last", 32'(req_ready), 32'd0);
    wait_cyc(t0 + 5);
    check("timeout_err_set", 32'(err), 32'd1);
    check("timeout_back_idle_accept", 32'(req_ready), 32'b100);
    wait_exp_empty(20);
    check("timeout_err_sticky", 32'(err), 32'd1);

    // Two lines "AB\n" and "XY\n" presented together
    wait_idle();
    do_reset();
    check("reset_clears_err", 32'(err), 32'd0);
    busy_len = 2;
    push_req(0, 8'h41); push_req(0, 8'h42); push_req(0, 8'h0A);
    push_req(1, 8'h58); push_req(1, 8'h59); push_req(1, 8'h0A);
`ifdef UART_ARB_LINE_LOCK_EN
    push_exp(8'h41, 0); push_exp(8'h42, 0); push_exp(8'h0A, 0);
    push_exp(8'h58, 1); push_exp(8'h59, 1); push_exp(8'h0A, 1);
`else
    push_exp(8'h41, 0); push_exp(8'h58, 1); push_exp(8'h42, 0);
    push_exp(8'h59, 1); push_exp(8'h0A, 0); push_exp(8'h0A, 1);
`endif
    wait_exp_empty(100);

    // Reset during WAIT_DONE while the UART stays busy
    wait_idle();
    do_reset();
    busy_len = 20;
    push_req(0, 8'h11);
    push_exp(8'h11, 0);
    wait_exp_empty(20);
    push_req(1, 8'h22);
    push_exp(8'h22, 1);
    repeat (4) @(negedge clk_48);
    check("midop_busy_high", 32'(tx_busy), 32'd1);
    check("midop_held_no_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midop_rst_tx_w", 32'(tx_w), 32'd0);
    check("midop_rst_tx_data", 32'(tx_data), 32'h00);
    check("midop_rst_grant_id", 32'(grant_id), 32'd0);
    check("midop_rst_err", 32'(err), 32'd0);
    check("midop_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk_48);
    rst_n = 1'b1;
    early = 0;
    k = 0;
    while (tx_busy && k < 40) begin
      if (req_ready != '0) early++;
      @(negedge clk_48);
      k++;
    end
    check("midop_no_accept_while_busy", 32'(early), 32'd0);
    wait_exp_empty(20);

    // UART externally busy at the first request
    wait_idle();
    do_reset();
    busy_len = 3;
    ext_busy = 1'b1;
    push_req(2, 8'h77);
    push_exp(8'h77, 2);
    early = 0;
    repeat (6) begin
      @(negedge clk_48);
      if (req_ready != '0) early++;
    end
    check("ext_busy_no_ready", 32'(early), 32'd0);
    ext_busy = 1'b0;
    wait_exp_empty(20);

    repeat (10) @(negedge clk_48);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 3, number of byte requesters (2..8).
REQ-002 Port clk_48 input 1, 48 MHz system clock, all logic on its rising edge.
REQ-003 Port rst_n input 1, reset, asynchronous, active-low.
REQ-004 Port req_valid input N_REQ, per-requester byte-available flag.
REQ-005 Port req_data input 8*N_REQ, requester i byte at bits [8i+7:8i].
REQ-006 Port req_ready output N_REQ, per-requester accept strobe, one-hot or zero.
REQ-007 Port tx_data output 8, byte to UART transmitter, registered.
REQ-008 Port tx_w output 1, UART write strobe, one-cycle pulse, registered.
REQ-009 Port tx_busy input 1, UART busy indicator, active high.
REQ-010 Port grant_id output $clog2(N_REQ), index of last accepted requester, registered.
REQ-011 Port err output 1, sticky flag: UART failed to assert busy after a write.

Function
REQ-012 Transfer from requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-013 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE; one-hot encoding.
REQ-014 IDLE: if tx_busy==0 and any eligible req_valid, pick winner, assert req_ready[winner] combinationally, latch byte into tx_data, set grant_id, go ISSUE; otherwise stay.
REQ-015 req_ready SHALL be 0 in every state except IDLE.
REQ-016 ISSUE: tx_w=1 for exactly this cycle, go WAIT_BUSY; tx_w=0 in all other states.
REQ-017 WAIT_BUSY: tx_busy==1 -> WAIT_DONE; after 4 cycles without busy -> set err, go IDLE.
REQ-018 WAIT_DONE: tx_busy==0 -> IDLE; no timeout.
REQ-019 Arbitration round-robin: search starts at grant_id+1, wraps modulo N_REQ; after reset, search starts at 0.
REQ-020 Simultaneous valids: exactly one accepted per byte; other valids held with ready=0.
REQ-021 req_valid dropping before acceptance: no transfer, no state change.
REQ-022 tx_data stable from ISSUE through return to IDLE.
REQ-023 Byte-to-byte throughput bounded only by UART busy time plus 3 overhead cycles.

Reset
REQ-024 rst_n low: state=IDLE, tx_w=0, tx_data=8'h00, grant_id=0, err=0, lock cleared, req_ready=0.
REQ-025 Reset mid-operation abandons the current byte; UART completes it independently; first post-reset accept waits for tx_busy==0.

Configuration
REQ-026 Macro UART_ARB_LINE_LOCK_EN defined: after accepting a byte other than 8'h0A from requester i, only requester i is eligible until it transfers 8'h0A; 8'h0A releases lock in the accept cycle.
REQ-027 Macro undefined: no lock; every byte arbitrated independently per REQ-019.
REQ-028 err timeout (REQ-017) SHALL also clear the lock when the macro is defined.

Structure
REQ-029 Package uart_pkg holds the state localparams (one-hot, no enum), BUSY_TIMEOUT=4, and LF=8'h0A.
REQ-030 Combinational round-robin picker in sub-module uart_arb_rr (inputs: eligible mask, start index; outputs: winner index, found flag).

Verification
REQ-031 Single requester 0 sends 8'h41 with UART model: req_ready[0] one cycle, tx_w pulse one cycle later, tx_data=8'h41.
REQ-032 All three valid continuously with bytes 8'hA0/B1/C2: accept order 0,1,2,0,1,2; one tx_w per busy period.
REQ-033 UART model never asserts busy: err=1 five cycles after tx_w, state back to IDLE, next request accepted.
REQ-034 Lock enabled, req0 "AB\n", req1 "XY\n" all valid together: output A,B,0A,X,Y,0A; lock disabled: A,X,B,Y,0A,0A.
REQ-035 rst_n low during WAIT_DONE with busy high: outputs reset immediately; no accept until busy falls.
REQ-036 tx_busy already high at first request (UART busy externally): no req_ready until busy low.
